// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the sipo_deser serial receiver.
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_e;

    localparam int SIPO_MAX_WIDTH = 16;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sipo_bitcnt.sv
// Received-bit counter: load-1 on word start, increment per data bit, clear on completion.
// term_o flags that the current increment is the one that reaches WIDTH.
module sipo_bitcnt
    import sipo_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic load1_i,
    input  logic zero_i,
    input  logic inc_i,
    output logic term_o
);

    localparam int CW = cnt_width(WIDTH);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Restart wins over completion, completion wins over a plain increment.
    always_comb begin
        cnt_d = cnt_q;
        if (load1_i) begin
            cnt_d = CW'(1);
        end else if (zero_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CW'(WIDTH))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_o = inc_i && (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out receiver: MSB-first WIDTH-bit words framed by sof, valid/ready output, sticky ovf.
// Build with SIPO_PARITY_EN defined to expect a trailing even-parity bit per word and drive perr.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sin_sof,
    input  logic             rdy,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic             v,
    output logic             perr,
    output logic             ovf,
    output logic             busy
);

    state_e           state_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] q_q;
    logic             v_q;
    logic             ovf_q;
    logic             busy_q;

    logic             restart;
    logic             shift_en;
    logic             term;
    logic             done;
    logic             drop;
    logic [WIDTH-1:0] sr_shift;
    logic [WIDTH-1:0] word;

    assign restart  = sin_valid && sin_sof;
    assign shift_en = sin_valid && !sin_sof && (state_q == SHIFT);
    assign sr_shift = {sr_q[WIDTH-2:0], sin};

`ifdef SIPO_PARITY_EN
    logic par_en;
    logic perr_q;

    assign par_en = sin_valid && !sin_sof && (state_q == PAR);
    assign done   = par_en;
    assign word   = sr_q;
    assign perr   = perr_q;
`else
    assign done   = shift_en && term;
    assign word   = sr_shift;
    assign perr   = 1'b0;
`endif

    // A word finishing while the previous one is still held and not taken is lost.
    assign drop = done && v_q && !rdy;

    sipo_bitcnt #(
        .WIDTH (WIDTH)
    ) u_bitcnt (
        .clk     (clk),
        .clr     (clr),
        .load1_i (restart),
        .zero_i  (done),
        .inc_i   (shift_en),
        .term_o  (term)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            sr_q    <= '0;
            q_q     <= '0;
            v_q     <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SIPO_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            if (restart) begin
                state_q <= SHIFT;
                busy_q  <= 1'b1;
                sr_q    <= WIDTH'(sin);
            end else if (shift_en) begin
                sr_q <= sr_shift;
                if (term) begin
`ifdef SIPO_PARITY_EN
                    state_q <= PAR;
                    busy_q  <= 1'b1;
`else
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
`endif
                end
`ifdef SIPO_PARITY_EN
            end else if (par_en) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
`endif
            end

            if (done) begin
                if (!drop) begin
                    q_q <= word;
                    v_q <= 1'b1;
`ifdef SIPO_PARITY_EN
                    perr_q <= (^sr_q) ^ sin;
`endif
                end
            end else if (v_q && rdy) begin
                v_q <= 1'b0;
            end

            if (drop) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign q    = q_q;
    assign v    = v_q;
    assign ovf  = ovf_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser (WIDTH=4) with a queue scoreboard checked on every accepted word.
module tb_sipo_deser;

`ifdef SIPO_PARITY_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       sin = 1'b0;
    logic       sin_valid = 1'b0;
    logic       sin_sof = 1'b0;
    logic       rdy = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [3:0] q;
    logic       v;
    logic       perr;
    logic       ovf;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int busy_hits = 0;
    logic [4:0] sb[$];

    sipo_deser #(.WIDTH(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .sin       (sin),
        .sin_valid (sin_valid),
        .sin_sof   (sin_sof),
        .rdy       (rdy),
        .ovf_clr   (ovf_clr),
        .q         (q),
        .v         (v),
        .perr      (perr),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Serial frame for data d with correct even parity appended when parity is built.
    function automatic logic [NB-1:0] frame(input logic [3:0] d);
`ifdef SIPO_PARITY_EN
        return {d, ^d};
`else
        return d;
`endif
    endfunction

    task automatic send_bit(input logic b, input logic sof);
        sin       = b;
        sin_sof   = sof;
        sin_valid = 1'b1;
        @(posedge clk);
        #1;
        busy_hits += int'(busy);
    endtask

    task automatic send_seq(input logic [NB-1:0] seq, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            send_bit(seq[NB-1-i], i == 0);
        end
        sin_valid = 1'b0;
        sin_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every accepted word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (clr && v && rdy) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", 32'({perr, q}), 32'h1ff);
            end else begin
                chk("word", 32'({perr, q}), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        idle(2);
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_v", 32'(v), 32'h0);
        chk("rst_perr", 32'(perr), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        clr = 1'b1;
        rdy = 1'b1;
        idle(1);

        // Basic word, back-to-back bits.
        sb.push_back({1'b0, 4'b1011});
        busy_hits = 0;
        send_seq(frame(4'b1011), 0, NB - 1);
        chk("t1_busy_cycles", 32'(busy_hits), 32'(NB - 1));
        chk("t1_v_set", 32'(v), 32'h1);
        idle(1);
        chk("t1_v_consumed", 32'(v), 32'h0);

        // Gap inside a word holds state.
        sb.push_back({1'b0, 4'b1001});
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        sin_valid = 1'b0;
        idle(3);
        chk("t2_busy_gap", 32'(busy), 32'h1);
        chk("t2_v_gap", 32'(v), 32'h0);
        send_seq(frame(4'b1001), 2, NB - 1);
        chk("t2_v_set", 32'(v), 32'h1);
        idle(1);

        // sof mid-word restarts.
        sb.push_back({1'b0, 4'b0110});
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_seq(frame(4'b0110), 0, NB - 1);
        chk("t3_ovf", 32'(ovf), 32'h0);
        idle(1);

        // Overrun with the consumer stalled.
        rdy = 1'b0;
        sb.push_back({1'b0, 4'b1100});
        send_seq(frame(4'b1100), 0, NB - 1);
        send_seq(frame(4'b0011), 0, NB - 1);
        chk("t4_q_held", 32'(q), 32'hc);
        chk("t4_v_held", 32'(v), 32'h1);
        chk("t4_ovf_set", 32'(ovf), 32'h1);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        chk("t4_ovf_clr", 32'(ovf), 32'h0);
        rdy = 1'b1;
        idle(1);
        chk("t4_v_drain", 32'(v), 32'h0);

        // Second word completes on the same edge the first is taken.
        rdy = 1'b0;
        sb.push_back({1'b0, 4'b1010});
        sb.push_back({1'b0, 4'b0101});
        send_seq(frame(4'b1010), 0, NB - 1);
        send_seq(frame(4'b0101), 0, NB - 2);
        chk("t5_v_wait", 32'(v), 32'h1);
        rdy = 1'b1;
        send_seq(frame(4'b0101), NB - 1, NB - 1);
        chk("t5_v_no_bubble", 32'(v), 32'h1);
        chk("t5_q_new", 32'(q), 32'h5);
        idle(2);

        // Asynchronous reset mid-word while a word is held and ovf is set.
        rdy = 1'b0;
        send_seq(frame(4'b1111), 0, NB - 1);
        send_seq(frame(4'b1000), 0, NB - 1);
        send_seq(frame(4'b0110), 0, 1);
        chk("t6_busy_pre", 32'(busy), 32'h1);
        chk("t6_ovf_pre", 32'(ovf), 32'h1);
        clr = 1'b0;
        #1;
        chk("t6_q", 32'(q), 32'h0);
        chk("t6_v", 32'(v), 32'h0);
        chk("t6_ovf", 32'(ovf), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_perr", 32'(perr), 32'h0);
        @(posedge clk);
        #1;
        clr = 1'b1;
        rdy = 1'b1;
        sb.push_back({1'b0, 4'b0110});
        send_seq(frame(4'b0110), 0, NB - 1);
        chk("t6_ovf_after", 32'(ovf), 32'h0);
        idle(1);

`ifdef SIPO_PARITY_EN
        sb.push_back({1'b0, 4'b1011});
        send_seq(5'b1011_1, 0, 3);
        chk("p_v_before_par", 32'(v), 32'h0);
        chk("p_busy_in_par", 32'(busy), 32'h1);
        send_seq(5'b1011_1, 4, 4);
        chk("p_v_after_par", 32'(v), 32'h1);
        chk("p_perr_good", 32'(perr), 32'h0);
        idle(1);
        sb.push_back({1'b1, 4'b1011});
        send_seq(5'b1011_0, 0, 4);
        chk("p_perr_bad", 32'(perr), 32'h1);
        idle(1);
`endif

        idle(3);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
